// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage and its IF/ID neighbour.
package if_fetch_stage_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned PC_INCR = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and holds
// the returned word until IF/ID consumes it; redirects squash any in-flight fetch.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCadderResult,
    output logic [XLEN-1:0] ReadData,
    output logic            FetchValid
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_inst_buf;
    logic [XLEN-1:0] w_inst_buf_nxt;
    logic            r_discard;
    logic            w_discard_nxt;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_inc;

    // Redirect targets are forced word-aligned; the PC increment wraps naturally.
    assign w_redir_pc = RedirectPC & ~XLEN'(3);
    assign w_pc_inc   = r_pc + XLEN'(PC_INCR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_inst_buf <= XLEN'(NOP_INSTR);
            r_discard  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst_buf <= w_inst_buf_nxt;
            r_discard  <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_buf_nxt = r_inst_buf;
        w_discard_nxt  = r_discard;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (Redirect) w_pc_nxt = w_redir_pc;
            end
            ST_REQ: begin
                if (Redirect) begin
                    w_pc_nxt = w_redir_pc;
                end else if (imem_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        if (Redirect) w_pc_nxt = w_redir_pc;
                    end else if (Redirect) begin
                        w_pc_nxt = w_redir_pc;
                    end else begin
                        w_inst_buf_nxt = imem_rdata;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (Redirect) begin
                    // Response still owed for the old address; drop it when it lands.
                    w_pc_nxt      = w_redir_pc;
                    w_discard_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = ST_REQ;
                end else if (PCWrite) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req      = (r_state == ST_REQ);
    assign imem_addr     = r_pc;
    assign PC            = r_pc;
    assign PCadderResult = w_pc_inc;
    assign FetchValid    = (r_state == ST_HOLD);
    assign ReadData      = FetchValid ? r_inst_buf : XLEN'(NOP_INSTR);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: vector table plus directed corner sequences,
// with request-address and delivered-instruction scoreboards.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] PCadderResult;
    logic [31:0] ReadData;
    logic        FetchValid;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCWrite      (PCWrite),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .PCadderResult(PCadderResult),
        .ReadData     (ReadData),
        .FetchValid   (FetchValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    int unsigned mem_lat  = 1;
    int unsigned mem_cnt  = 0;
    logic [31:0] mem_data = 32'h0;
    logic        prev_fv  = 1'b0;

    typedef struct {
        logic        pcwrite;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic        exp_fv;
        logic [31:0] exp_rd;
        logic [31:0] exp_add;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] pc,
                            input logic fv, input logic [31:0] rd, input logic [31:0] add);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(req));
        if (req) chk({tag, ".imem_addr"}, imem_addr, pc);
        chk({tag, ".PC"}, PC, pc);
        chk({tag, ".FetchValid"}, 32'(FetchValid), 32'(fv));
        chk({tag, ".ReadData"}, ReadData, rd);
        chk({tag, ".PCadderResult"}, PCadderResult, add);
    endtask

    // One clock: scoreboard accepted requests, then advance the memory response model.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] e;
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        if (acc) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: addr %h accepted, none expected", acc_addr);
            end else begin
                e = exp_addr_q.pop_front();
                chk("req_addr", acc_addr, e);
            end
        end
        #1;
        if (acc) mem_cnt = mem_lat;
        imem_rvalid = (mem_cnt == 1);
        imem_rdata  = imem_rvalid ? mem_data : 32'h0;
        if (mem_cnt > 0) mem_cnt--;
        if (FetchValid && !prev_fv) begin
            if (exp_inst_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: ReadData %h presented, none expected", ReadData);
            end else begin
                e = exp_inst_q.pop_front();
                chk("fetch_data", ReadData, e);
            end
        end
        prev_fv = FetchValid;
    endtask

    localparam logic [31:0] D0 = 32'h2008_0005;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h4};
        vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b1, D0,    32'h4};
        vecs[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h8};
        vecs[4] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h8};
        vecs[5] = '{1'b1, 1'b0, 32'h4, 1'b1, D0,    32'h8};
        vecs[6] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'hC};
        vecs[7] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'hC};
        vecs[8] = '{1'b1, 1'b0, 32'h8, 1'b1, D0,    32'hC};

        rst         = 1'b0;
        PCWrite     = 1'b1;
        Redirect    = 1'b0;
        RedirectPC  = 32'h0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_lat     = 1;
        mem_data    = D0;

        tick();
        tick();
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
        rst = 1'b1;

        // Zero-wait streaming: one instruction every third cycle.
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) exp_inst_q.push_back(D0);
        for (int i = 0; i < 9; i++) begin
            PCWrite = vecs[i].pcwrite;
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_pc,
                     vecs[i].exp_fv, vecs[i].exp_rd, vecs[i].exp_add);
        end

        // Stall in HOLD for 5 cycles.
        PCWrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs("stall", 1'b0, 32'h8, 1'b1, D0, 32'hC);
        end
        exp_addr_q.push_back(32'hC);
        PCWrite = 1'b1;
        tick();
        chk_outs("stall_release", 1'b1, 32'hC, 1'b0, 32'h0, 32'h10);
        PCWrite = 1'b0;

        // Redirect while WAIT; late DEAD_BEEF must be discarded.
        mem_lat  = 3;
        mem_data = 32'hDEAD_BEEF;
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0100;
        tick();
        Redirect = 1'b0;
        chk_outs("wait_redirect", 1'b0, 32'h100, 1'b0, 32'h0, 32'h104);
        tick();
        chk("discard_rvalid_seen", 32'(imem_rvalid), 32'h1);
        tick();
        chk_outs("after_discard", 1'b1, 32'h100, 1'b0, 32'h0, 32'h104);

        // Redirect coincident with rvalid: data dropped.
        exp_addr_q.push_back(32'h100);
        mem_lat  = 1;
        mem_data = 32'h1111_0001;
        tick();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0200;
        tick();
        Redirect = 1'b0;
        chk_outs("rvalid_redirect", 1'b1, 32'h200, 1'b0, 32'h0, 32'h204);

        exp_addr_q.push_back(32'h200);
        mem_data = 32'h2222_0002;
        exp_inst_q.push_back(32'h2222_0002);
        tick();
        tick();
        chk_outs("hold_200", 1'b0, 32'h200, 1'b1, 32'h2222_0002, 32'h204);
        exp_addr_q.push_back(32'h204);
        PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;

        // Asynchronous reset mid-WAIT, then a late rvalid while IDLE.
        mem_lat  = 2;
        mem_data = 32'hBAD0_BAD0;
        tick();
        #2 rst = 1'b0;
        #1;
        chk_outs("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
        imem_ready = 1'b0;
        tick();
        rst = 1'b1;
        chk("late_rvalid_seen", 32'(imem_rvalid), 32'h1);
        chk_outs("idle_late_rvalid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4);
        tick();
        chk_outs("post_reset_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);

        // Redirect in HOLD to a misaligned address near the top, then wrap.
        imem_ready = 1'b1;
        mem_lat    = 1;
        mem_data   = 32'h4444_0004;
        exp_addr_q.push_back(32'h0);
        exp_inst_q.push_back(32'h4444_0004);
        tick();
        tick();
        chk_outs("hold_0", 1'b0, 32'h0, 1'b1, 32'h4444_0004, 32'h4);
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFE;
        tick();
        Redirect = 1'b0;
        chk_outs("hold_redirect", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        exp_addr_q.push_back(32'hFFFF_FFFC);
        mem_data = 32'h3333_0003;
        exp_inst_q.push_back(32'h3333_0003);
        tick();
        tick();
        chk_outs("hold_top", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h3333_0003, 32'h0);
        exp_addr_q.push_back(32'h0);
        PCWrite = 1'b1;
        tick();
        PCWrite = 1'b0;
        chk_outs("wrap", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4);
        mem_data = 32'h5555_0005;
        exp_inst_q.push_back(32'h5555_0005);
        tick();
        tick();
        chk_outs("hold_wrap", 1'b0, 32'h0, 1'b1, 32'h5555_0005, 32'h4);

        chk("addr_q_left", 32'(exp_addr_q.size()), 32'h0);
        chk("inst_q_left", 32'(exp_inst_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
